// File: rtl/uart_tx_sched_pkg.sv
// Shared types and default timing for the rs232c transmit scheduler.
// State encoding, the common counter type and its saturating increment.
package uart_tx_sched_pkg;

  localparam int CNT_W        = 16;
  localparam int DEF_EN_HOLD  = 4;
  localparam int DEF_GAP_CYC  = 2;
  localparam int DEF_BUSY_TMO = 65535;
  localparam int DEF_LOCK_TMO = 4095;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_e;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t cnt_inc(input cnt_t c);
    return (c == '1) ? c : c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side and transmitter-side signals of the scheduler.
// A byte moves from requester i when REQ_VALID[i] & REQ_READY[i] are both high at a CLK edge;
// a requester holds VALID/DATA/LAST stable until that happens, READY never depends on it being held.
interface uart_tx_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   REQ_VALID;
  logic [8*NREQ-1:0] REQ_DATA;
  logic [NREQ-1:0]   REQ_LAST;
  logic [NREQ-1:0]   REQ_READY;
  logic [NREQ-1:0]   GRANT;
  logic [7:0]        TX_DATA;
  logic              TX_DATA_EN;
  logic              TX_BUSY;
  logic              TMO_ERR;
  logic              ERR_CLR;

  modport master (
    output REQ_VALID, REQ_DATA, REQ_LAST, TX_BUSY, ERR_CLR,
    input  REQ_READY, GRANT, TX_DATA, TX_DATA_EN, TMO_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_DATA, REQ_LAST, TX_BUSY, ERR_CLR,
    output REQ_READY, GRANT, TX_DATA, TX_DATA_EN, TMO_ERR
  );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Kept generic so other shared ports can reuse it.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin : pick
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one rs232c transmitter among NREQ byte sources: round-robin pick, packet lock,
// stretched TX_DATA_EN pulse, wait for TX_BUSY to drop, then an idle gap.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int EN_HOLD  = DEF_EN_HOLD,
  parameter  int GAP_CYC  = DEF_GAP_CYC,
  parameter  int BUSY_TMO = DEF_BUSY_TMO,
  parameter  int LOCK_TMO = DEF_LOCK_TMO,
  localparam int IW       = $clog2(NREQ)
) (
  input  logic           CLK,
  input  logic           RESET,
  uart_tx_sched_if.slave bus,
  output state_e         dbg_state
);

  state_e          state_q, state_d;
  cnt_t            cnt_q, cnt_d;
  logic            lock_q, lock_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_en_q, tx_en_d;
  logic            tmo_err_q, tmo_err_d;

  logic [NREQ-1:0] owner_oh, elig, arb_gnt;
  logic [IW-1:0]   arb_idx, ptr_after;
  logic            arb_any;
  logic [7:0]      sel_byte;

  // While locked only the owner may win, so the pointer value is irrelevant then.
  assign owner_oh  = NREQ'(1) << owner_q;
  assign elig      = lock_q ? (bus.REQ_VALID & owner_oh) : bus.REQ_VALID;
  assign sel_byte  = bus.REQ_DATA[{arb_idx, 3'b000} +: 8];
  assign ptr_after = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);

  rr_arbiter #(.N(NREQ)) u_arb (
    .req (elig),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign bus.REQ_READY  = (state_q == ST_IDLE && !RESET) ? arb_gnt : '0;
  assign bus.GRANT      = grant_q;
  assign bus.TX_DATA    = tx_data_q;
  assign bus.TX_DATA_EN = tx_en_q;
  assign bus.TMO_ERR    = tmo_err_q;
  assign dbg_state      = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lock_d    = lock_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    tmo_err_d = bus.ERR_CLR ? 1'b0 : tmo_err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d   = ST_LOAD;
          cnt_d     = '0;
          tx_en_d   = 1'b1;
          tx_data_d = sel_byte;
          grant_d   = arb_gnt;
          owner_d   = arb_idx;
          ptr_d     = ptr_after;
          lock_d    = !bus.REQ_LAST[arb_idx];
        end else if (lock_q) begin
          // Owner went quiet mid-packet; give the port back after LOCK_TMO idle cycles.
          cnt_d = cnt_inc(cnt_q);
          if (cnt_d >= cnt_t'(LOCK_TMO)) begin
            lock_d  = 1'b0;
            grant_d = '0;
            cnt_d   = '0;
          end
        end
      end
      ST_LOAD: begin
        tx_en_d = 1'b1;
        if (cnt_q >= cnt_t'(EN_HOLD - 1)) begin
          tx_en_d = 1'b0;
          state_d = ST_WAIT_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.TX_BUSY) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc(cnt_q);
          if (cnt_d >= cnt_t'(BUSY_TMO)) begin
            tmo_err_d = 1'b1;
            lock_d    = 1'b0;
            state_d   = ST_GAP;
            cnt_d     = '0;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q >= cnt_t'(GAP_CYC - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (!lock_q) grant_d = '0;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      lock_q    <= 1'b0;
      owner_q   <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      tmo_err_q <= tmo_err_d;
    end
  end

endmodule
